yutorina_alu_mc: RTL
====================

Name: yutorina_alu_mc

Overview:
Parametrised, multi-cycle successor to the single-cycle ALU in the execute stage.
- Handles all existing logic/arithmetic/shift ops with 1-cycle registered latency.
- Adds SRA plus iterative MUL/DIVU/REMU using a req/ready/valid handshake.
- The EX stage stalls the pipeline while ready=0.

Parameters:
- DATA_W, 32, operand/result width; must be a power of two, 8 to 64.
- SHAMT_W, $clog2(DATA_W), number of rhs LSBs used as the shift amount.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  operation request; accepted when req && ready at a rising edge
- op  in  4  operation code (encoding below)
- lhs  in  DATA_W  left operand
- rhs  in  DATA_W  right operand
- ready  out  1  block can accept a request this cycle
- valid  out  1  one-cycle pulse: ret/div_zero hold a new result
- ret  out  DATA_W  result; holds its value until the next completion
- div_zero  out  1  last completed DIVU/REMU had rhs==0; updated on every completion

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 NOR: bitwise ~(lhs|rhs).
  - 6 SLTU: unsigned less-than, result 1 or 0.
  - 7 SLL, 8 SRL (logical), 9 SRA (arithmetic).
  - 10 MUL: low DATA_W bits of the unsigned product.
  - 11 DIVU, 12 REMU.
  - 13-15 undefined: result 0, treated as a single-cycle op.
- Shifts use rhs[SHAMT_W-1:0] only; upper rhs bits are ignored.
- All arithmetic wraps modulo 2^DATA_W; no flags other than div_zero.
- Reset values: ready=1, valid=0, ret=0, div_zero=0, state=IDLE, all internal counters and registers 0.
- States: IDLE, MUL, DIV.
  - IDLE, ready=1:
    - Single-cycle op accepted at edge N: ret/div_zero registered at N, valid=1 during cycle N+1, state stays IDLE.
    - Back-to-back requests are allowed: a new accept is possible in every cycle.
  - MUL: entered at accept edge N; ready=0.
    - Shift-add, 1 bit per cycle, over DATA_W iteration edges N+1..N+DATA_W.
    - Result is registered at edge N+DATA_W; returns to IDLE at that edge; valid=1 in the following cycle.
  - DIV: restoring division, 1 quotient bit per cycle, same timing as MUL.
    - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero is detected at accept and never enters DIV; it completes with 1-cycle latency:
  - DIVU ret = all ones; REMU ret = lhs; div_zero=1.
- Any other completion clears div_zero.
- Operands are captured at accept; lhs/rhs/op may change freely while ready=0.
- req while ready=0 is ignored (not queued); the requester must hold req until ready=1.
- valid is high for exactly one cycle per accepted request, never without an accept.
- Reset mid-operation: aborts the iteration, no valid is produced, all outputs return to reset values on that edge.

Optional Feature:
YUTORINA_ALU_MULDIV_EN
- Defined: MUL/DIVU/REMU behave as above; the MUL and DIV states and datapath are instantiated.
- Undefined:
  - Ops 10-12 are treated as undefined: ret=0, 1-cycle latency, div_zero=0.
  - No MUL/DIV state or datapath is synthesised; ready is constant 1.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+1 -> valid one cycle after accept, ret=0x80000000; then SUB 0-1 on the next cycle -> ret=0xFFFFFFFF; back-to-back valids.
- NOR 0,0 -> 0xFFFFFFFF; SLTU 3,5 -> 1; SLL 1,33 -> 2 (shift amount masked to 1); SRA 0x80000000,4 -> 0xF8000000; SRL 0x80000000,4 -> 0x08000000.
- MUL 7*6 (DATA_W=32): ready=0 for 32 cycles, valid in cycle N+33, ret=42; MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- DIVU 100/7 -> 14 and REMU 100/7 -> 2, each with 32-cycle busy and div_zero=0; DIVU 5/0 -> 1-cycle latency, ret=0xFFFFFFFF, div_zero=1; REMU 5/0 -> ret=5, div_zero=1.
- Hold req with a new ADD during a MUL busy period -> no accept until ready=1, then exactly one valid per request; change lhs mid-MUL -> result unaffected.
- Assert reset at iteration 10 of a DIVU -> no valid pulse, ready=1, ret=0, div_zero=0 next cycle; a fresh request then completes correctly.

Source files
------------

// File: rtl/yutorina_alu_mc.sv
// ============================================================================
// Module   : yutorina_alu_mc
// Brief    : Multi-cycle execute-stage ALU. Single-cycle logic/arith/shift ops
//            plus iterative MUL/DIVU/REMU behind a req/ready/valid handshake.
//            Optional macro: YUTORINA_ALU_MULDIV_EN (enables MUL/DIVU/REMU).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module yutorina_alu_mc #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] lhs,
    input  logic [DATA_W-1:0] rhs,
    output logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] ret,
    output logic              div_zero
);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_nor  = 4'd5;
    localparam logic [3:0] c_op_sltu = 4'd6;
    localparam logic [3:0] c_op_sll  = 4'd7;
    localparam logic [3:0] c_op_srl  = 4'd8;
    localparam logic [3:0] c_op_sra  = 4'd9;

    logic              r_valid;
    logic [DATA_W-1:0] r_ret;
    logic              r_div_zero;

    logic [SHAMT_W-1:0] w_shamt;
    logic [DATA_W-1:0]  w_alu;

    assign valid    = r_valid;
    assign ret      = r_ret;
    assign div_zero = r_div_zero;

    // Only the low rhs bits form the shift amount; the rest are ignored.
    assign w_shamt = rhs[SHAMT_W-1:0];

    // Single-cycle result; unknown opcodes (and MUL/DIV ops here) give zero.
    always_comb begin
        w_alu = '0;
        case (op)
            c_op_add:  w_alu = lhs + rhs;
            c_op_sub:  w_alu = lhs - rhs;
            c_op_and:  w_alu = lhs & rhs;
            c_op_or:   w_alu = lhs | rhs;
            c_op_xor:  w_alu = lhs ^ rhs;
            c_op_nor:  w_alu = ~(lhs | rhs);
            c_op_sltu: w_alu = {{(DATA_W-1){1'b0}}, (lhs < rhs)};
            c_op_sll:  w_alu = lhs << w_shamt;
            c_op_srl:  w_alu = lhs >> w_shamt;
            c_op_sra:  w_alu = $signed(lhs) >>> w_shamt;
            default:   w_alu = '0;
        endcase
    end

`ifdef YUTORINA_ALU_MULDIV_EN

    localparam logic [3:0] c_op_mul  = 4'd10;
    localparam logic [3:0] c_op_divu = 4'd11;
    localparam logic [3:0] c_op_remu = 4'd12;
    localparam int         c_cnt_w   = $clog2(DATA_W);

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_mul  = 2'd1,
        st_div  = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    // r_acc: product accumulator / partial remainder
    // r_opa: shifted multiplicand / dividend-then-quotient shift register
    // r_opb: multiplier (shifted right) / divisor
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  r_opa;
    logic [DATA_W-1:0]  r_opb;
    logic               r_want_rem;

    logic [DATA_W-1:0]  w_mul_acc;
    logic [DATA_W:0]    w_rem_sh;
    logic [DATA_W:0]    w_diff;
    logic               w_fits;
    logic [DATA_W-1:0]  w_div_rem;
    logic [DATA_W-1:0]  w_div_quo;
    logic               w_last;

    assign ready = (r_state == st_idle);

    assign w_mul_acc = r_opb[0] ? (r_acc + r_opa) : r_acc;

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    assign w_rem_sh  = {r_acc, r_opa[DATA_W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_opb};
    assign w_fits    = ~w_diff[DATA_W];
    assign w_div_rem = w_fits ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
    assign w_div_quo = {r_opa[DATA_W-2:0], w_fits};

    assign w_last = (r_cnt == c_cnt_w'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= st_idle;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_want_rem <= 1'b0;
            r_valid    <= 1'b0;
            r_ret      <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                st_idle: begin
                    if (req) begin
                        case (op)
                            c_op_mul: begin
                                r_state <= st_mul;
                                r_cnt   <= '0;
                                r_acc   <= '0;
                                r_opa   <= lhs;
                                r_opb   <= rhs;
                            end
                            c_op_divu, c_op_remu: begin
                                if (rhs == '0) begin
                                    r_ret      <= (op == c_op_divu) ? '1 : lhs;
                                    r_div_zero <= 1'b1;
                                    r_valid    <= 1'b1;
                                end else begin
                                    r_state    <= st_div;
                                    r_cnt      <= '0;
                                    r_acc      <= '0;
                                    r_opa      <= lhs;
                                    r_opb      <= rhs;
                                    r_want_rem <= (op == c_op_remu);
                                end
                            end
                            default: begin
                                r_ret      <= w_alu;
                                r_div_zero <= 1'b0;
                                r_valid    <= 1'b1;
                            end
                        endcase
                    end
                end
                st_mul: begin
                    r_acc <= w_mul_acc;
                    r_opa <= r_opa << 1;
                    r_opb <= r_opb >> 1;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        r_state    <= st_idle;
                        r_cnt      <= '0;
                        r_ret      <= w_mul_acc;
                        r_div_zero <= 1'b0;
                        r_valid    <= 1'b1;
                    end
                end
                st_div: begin
                    r_acc <= w_div_rem;
                    r_opa <= w_div_quo;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        r_state    <= st_idle;
                        r_cnt      <= '0;
                        r_ret      <= r_want_rem ? w_div_rem : w_div_quo;
                        r_div_zero <= 1'b0;
                        r_valid    <= 1'b1;
                    end
                end
                default: r_state <= st_idle;
            endcase
        end
    end

`else

    // Without the iterative unit every op completes in one cycle.
    assign ready = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_ret      <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_valid <= req;
            if (req) begin
                r_ret      <= w_alu;
                r_div_zero <= 1'b0;
            end
        end
    end

`endif

endmodule

`default_nettype wire
